// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-queue front end for the 8-bit ALU datapath.
// The CPU stages operands A/B, then pushes {op, A, B} into a command FIFO.
// An issue FSM (IDLE/EXEC) drives one command at a time onto the ALU,
// captures alu_out one cycle later and stores it in a result FIFO.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   ui_in[7:0]          PMOD input (unused)
//   uo_out[7:0]         {6'b0, res_nonempty, busy}
//   address[3:0]        register address
//   data_write          1-cycle write strobe
//   data_in[7:0]        write data
//   data_out[7:0]       read data, combinational from address
//   alu_a/alu_b[7:0]    registered ALU operands
//   alu_op[3:0]         registered ALU opcode (0 = add, 1 = sub)
//   alu_out[7:0]        combinational ALU result
//
// Optional feature macro: ALU_CMD_SEQ_ERR_FLAG_EN
//   defined   -> sticky err flag (status bit 7), cleared by 0x6 bit1
//   undefined -> status bit 7 reads 0, 0x6 bit1 ignored
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_out
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned CMDW = 20;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t              r_state;
  logic [7:0]          r_a_stage, r_b_stage;
  logic [CMDW-1:0]     r_cmd_mem [DEPTH];
  logic [PW-1:0]       r_cmd_wp, r_cmd_rp;
  logic [CW-1:0]       r_cmd_cnt;
  logic [7:0]          r_res_mem [DEPTH];
  logic [PW-1:0]       r_res_wp, r_res_rp;
  logic [CW-1:0]       r_res_cnt;
  logic [7:0]          r_alu_a, r_alu_b;
  logic [3:0]          r_alu_op;

  logic w_wr_a, w_wr_b, w_wr_push, w_wr_pop, w_wr_ctrl;
  logic w_cmd_full, w_res_full, w_res_nonempty;
  logic w_cmd_push, w_issue, w_res_push, w_res_pop, w_flush;
  logic w_busy, w_err;
  logic w_unused;

  // Bus write decode
  assign w_wr_a    = data_write && (address == 4'h0);
  assign w_wr_b    = data_write && (address == 4'h1);
  assign w_wr_push = data_write && (address == 4'h2);
  assign w_wr_pop  = data_write && (address == 4'h4);
  assign w_wr_ctrl = data_write && (address == 4'h6);

  assign w_cmd_full     = (r_cmd_cnt == CW'(DEPTH));
  assign w_res_full     = (r_res_cnt == CW'(DEPTH));
  assign w_res_nonempty = (r_res_cnt != '0);

  // Push to a full command FIFO is dropped; full is judged before the edge
  assign w_cmd_push = w_wr_push && !w_cmd_full;
  assign w_issue    = (r_state == S_IDLE) && (r_cmd_cnt != '0) && !w_res_full;
  assign w_res_push = (r_state == S_EXEC);
  assign w_res_pop  = w_wr_pop && w_res_nonempty;
  assign w_flush    = w_wr_ctrl && data_in[0];

  assign w_busy   = (r_state == S_EXEC) || (r_cmd_cnt != '0);
  assign w_unused = ^ui_in;

  // Staging, FIFOs and issue FSM; flush overrides all FIFO/FSM activity
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a_stage <= '0;
      r_b_stage <= '0;
      r_cmd_wp  <= '0;
      r_cmd_rp  <= '0;
      r_cmd_cnt <= '0;
      r_res_wp  <= '0;
      r_res_rp  <= '0;
      r_res_cnt <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_cmd_mem[i] <= '0;
        r_res_mem[i] <= '0;
      end
    end else begin
      if (w_wr_a) r_a_stage <= data_in;
      if (w_wr_b) r_b_stage <= data_in;

      if (w_flush) begin
        r_state   <= S_IDLE;
        r_cmd_wp  <= '0;
        r_cmd_rp  <= '0;
        r_cmd_cnt <= '0;
        r_res_wp  <= '0;
        r_res_rp  <= '0;
        r_res_cnt <= '0;
      end else begin
        if (w_cmd_push) begin
          r_cmd_mem[r_cmd_wp] <= {data_in[3:0], r_a_stage, r_b_stage};
          r_cmd_wp            <= r_cmd_wp + PW'(1);
        end

        case (r_state)
          S_IDLE: begin
            if (w_issue) begin
              {r_alu_op, r_alu_a, r_alu_b} <= r_cmd_mem[r_cmd_rp];
              r_cmd_rp <= r_cmd_rp + PW'(1);
              r_state  <= S_EXEC;
            end
          end
          S_EXEC: begin
            r_res_mem[r_res_wp] <= alu_out;
            r_res_wp            <= r_res_wp + PW'(1);
            r_state             <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase

        if (w_res_pop) r_res_rp <= r_res_rp + PW'(1);

        r_cmd_cnt <= r_cmd_cnt + CW'(w_cmd_push) - CW'(w_issue);
        r_res_cnt <= r_res_cnt + CW'(w_res_push) - CW'(w_res_pop);
      end
    end
  end

`ifdef ALU_CMD_SEQ_ERR_FLAG_EN
  logic r_err;
  logic w_err_set, w_err_clr;

  assign w_err_set = (w_wr_push && w_cmd_full) || (w_wr_pop && !w_res_nonempty);
  assign w_err_clr = w_wr_ctrl && data_in[1];

  // Sticky error; a same-cycle set beats a clear
  always_ff @(posedge clk) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
    else if (w_err_clr) r_err <= 1'b0;
  end

  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  assign alu_a  = r_alu_a;
  assign alu_b  = r_alu_b;
  assign alu_op = r_alu_op;
  assign uo_out = {6'b0, w_res_nonempty, w_busy};

  // Register read mux
  always_comb begin
    data_out = '0;
    case (address)
      4'h0: data_out = r_a_stage;
      4'h1: data_out = r_b_stage;
      4'h3: data_out = w_res_nonempty ? r_res_mem[r_res_rp] : 8'h00;
      4'h5: data_out = {w_err, w_busy, 3'(r_res_cnt), 3'(r_cmd_cnt)};
      default: data_out = '0;
    endcase
  end

endmodule
